// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings, FSM states and size helpers for the MEM-stage access unit
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SZ_BYTE: byte_count = 3'd1;
            SZ_HALF: byte_count = 3'd2;
            default: byte_count = 3'd4;
        endcase
    endfunction

    // Reserved size is rejected outright, whatever the address.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = addr_lo[0];
            SZ_WORD: is_misaligned = (addr_lo != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_extend.sv
// rtl/mem_load_extend.sv - sign/zero extension of assembled little-endian load lanes
module mem_load_extend
    import mem_access_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] raw_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = raw_i;
        case (size_i)
            SZ_BYTE: data_o = {{24{~unsigned_i & raw_i[7]}}, raw_i[7:0]};
            SZ_HALF: data_o = {{16{~unsigned_i & raw_i[15]}}, raw_i[15:0]};
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - splits one load/store into byte transfers over a req/ack memory port
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       exmem_alu_i,
    input  logic [31:0]       exmem_mux7_i,
    input  logic              exmem_m_MW_i,
    input  logic              exmem_m_MR_i,
    input  logic [1:0]        exmem_size_i,
    input  logic              exmem_unsigned_i,
    output logic              stall_o,
    output logic [31:0]       load_data_o,
    output logic              load_valid_o,
    output logic              misaligned_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i,
    input  logic              mem_ack_i
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       lanes_q, lanes_d;
    logic [31:0]       load_q, load_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              we_q, we_d;
    logic [2:0]        cnt_q, cnt_d;

    logic              req_present;
    logic              reject;
    logic              accept;
    logic              xfer_ack;
    logic              last_byte;
    logic [31:0]       ext_data;
    logic [7:0]        wr_byte;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^exmem_alu_i[31:ADDR_W];

    // A simultaneous MW and MR is treated as a store.
    assign req_present = exmem_m_MW_i | exmem_m_MR_i;
    assign reject      = req_present & is_misaligned(exmem_size_i, exmem_alu_i[1:0]);
    assign accept      = (state_q == ST_IDLE) & req_present & ~reject;
    assign xfer_ack    = (state_q == ST_XFER) & mem_ack_i;
    assign last_byte   = ((cnt_q + 3'd1) == byte_count(size_q));
    assign wr_byte     = wdata_q[{cnt_q[1:0], 3'b000} +: 8];

    mem_load_extend u_extend (
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .raw_i      (lanes_d),
        .data_o     (ext_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_XFER;
            ST_XFER: if (mem_ack_i && last_byte) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stall_o      = 1'b0;
        misaligned_o = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        load_valid_o = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = 8'h00;
        case (state_q)
            ST_IDLE: begin
                stall_o      = accept;
                misaligned_o = reject;
            end
            ST_XFER: begin
                stall_o     = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = we_q;
                mem_addr_o  = addr_q + ADDR_W'(cnt_q);
                mem_wdata_o = wr_byte;
            end
            ST_DONE: load_valid_o = ~we_q;
            default: ;
        endcase
    end

    assign load_data_o = load_q;

    // Raw lanes including the byte arriving this cycle, so the final ack can extend in one step.
    always_comb begin
        lanes_d = lanes_q;
        if (accept) begin
            lanes_d = '0;
        end else if (xfer_ack && !we_q) begin
            lanes_d[{cnt_q[1:0], 3'b000} +: 8] = mem_rdata_i;
        end
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        if (accept) begin
            addr_d  = exmem_alu_i[ADDR_W-1:0];
            wdata_d = exmem_mux7_i;
            size_d  = exmem_size_i;
            uns_d   = exmem_unsigned_i;
            we_d    = exmem_m_MW_i;
            cnt_d   = 3'd0;
        end else if (xfer_ack) begin
            cnt_d = cnt_q + 3'd1;
            if (!we_q && last_byte) begin
                load_d = ext_data;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            lanes_q <= '0;
            load_q  <= '0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lanes_q <= lanes_d;
            load_q  <= load_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
